// File: rtl/mysystem_pio_gen_pkg.sv
// Shared register offsets and encodings for the
// parametrised GPIO slave.
package mysystem_pio_gen_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_MASK   = 3'd2;
  localparam logic [2:0] REG_EDGE   = 3'd3;
  localparam logic [2:0] REG_OUTSET = 3'd4;
  localparam logic [2:0] REG_OUTCLR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_EDGE  = 0;
  localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/mysystem_pio_gen_sync_edge.sv
// Pin synchroniser plus previous-value flop and
// edge selection for the GPIO input path.
module mysystem_pio_gen_sync_edge
  import mysystem_pio_gen_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      in_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = in_sync & ~in_prev;
  assign fall    = ~in_sync & in_prev;

  assign edge_det = (EDGE_TYPE == EDGE_FALL) ? fall :
                    (EDGE_TYPE == EDGE_ANY)  ? (rise | fall) :
                                               rise;

endmodule

// File: rtl/mysystem_pio_gen.sv
// Avalon-MM GPIO slave: data/direction/mask registers,
// atomic set/clear, edge capture and maskable irq.
module mysystem_pio_gen
  import mysystem_pio_gen_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               IRQ_MODE    = IRQ_EDGE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] rd_val;
  logic             wr;
  logic             wr_data;
  logic             wr_set;
  logic             wr_clr;
  logic             unused_wd;

  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr && (address == REG_DATA);
  assign wr_set    = wr && (address == REG_OUTSET);
  assign wr_clr    = wr && (address == REG_OUTCLR);
  assign edge_clr  = (wr && address == REG_EDGE) ? wd : '0;

  mysystem_pio_gen_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .in_sync  (in_sync),
    .edge_det (edge_det)
  );

  always_comb begin
    out_nxt = out_reg;
    unique case (1'b1)
      wr_data: out_nxt = wd;
      wr_set:  out_nxt = out_reg | wd;
      wr_clr:  out_nxt = out_reg & ~wd;
      default: out_nxt = out_reg;
    endcase
  end

  // New edges are OR'd in after the clear so a same-cycle edge survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= RESET_VALUE;
      dir_reg  <= RESET_DIR;
      mask_reg <= '0;
      edge_cap <= '0;
    end else begin
      out_reg  <= out_nxt;
      edge_cap <= (edge_cap & ~edge_clr) | edge_det;
      if (wr && address == REG_DIR)
        dir_reg <= wd;
      if (wr && address == REG_MASK)
        mask_reg <= wd;
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (address)
      REG_DATA: rd_val = (out_reg & dir_reg) | (in_sync & ~dir_reg);
      REG_DIR:  rd_val = dir_reg;
      REG_MASK: rd_val = mask_reg;
      REG_EDGE: rd_val = edge_cap;
      default:  rd_val = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_val;
  end

  assign out_port = out_reg;
  assign oe       = dir_reg;
  assign irq      = (IRQ_MODE == IRQ_LEVEL) ? |(in_sync & mask_reg)
                                            : |(edge_cap & mask_reg);

endmodule

// File: tb/tb_mysystem_pio_gen.sv
// Scoreboard bench for the GPIO slave: register map,
// set/clear, input sync, edge capture, irq and reset.
module tb_mysystem_pio_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] out_port;
  logic [W-1:0] oe;
  logic         irq;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  mysystem_pio_gen #(
    .WIDTH       (W),
    .RESET_VALUE (8'hA5),
    .RESET_DIR   (8'h00),
    .EDGE_TYPE   (0),
    .IRQ_MODE    (0),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got=running need=finished");
    $fatal(1, "watchdog");
  end

  // All bus tasks are entered just after a falling edge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    v          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] v;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb.push_back('{"rst_out_port", 32'hA5});
    sb.push_back('{"rst_oe", 32'h00});
    sb.push_back('{"rst_irq", 32'h0});
    sb.push_back('{"rst_edge", 32'h0});
    e = sb.pop_front(); n_checks++;
    if ({24'h0, out_port} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, out_port, e.val);
    end
    e = sb.pop_front(); n_checks++;
    if ({24'h0, oe} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, oe, e.val);
    end
    e = sb.pop_front(); n_checks++;
    if ({31'h0, irq} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, irq, e.val);
    end
    bus_read(3'd3, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0]  addrs [3] = '{3'd0, 3'd4, 3'd5};
    logic [31:0] datas [3] = '{32'h3C, 32'h81, 32'h0C};
    logic [31:0] v;
    sb.push_back('{"b2b_data", 32'h3C});
    sb.push_back('{"b2b_outset", 32'hBD});
    sb.push_back('{"b2b_outclr", 32'hB1});
    chipselect = 1'b1;
    write_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      address   = addrs[i];
      writedata = datas[i];
      @(negedge clk);
      e = sb.pop_front(); n_checks++;
      if ({24'h0, out_port} !== e.val) begin
        n_fail++;
        $display("FAIL %s got=%h need=%h", e.name, out_port, e.val);
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    sb.push_back('{"read_outset_zero", 32'h0});
    bus_read(3'd4, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
    // write strobe without chipselect must not land
    sb.push_back('{"cs_low_write", 32'hB1});
    address   = 3'd0;
    writedata = 32'h00;
    write_n   = 1'b0;
    @(negedge clk);
    write_n   = 1'b1;
    e = sb.pop_front(); n_checks++;
    if ({24'h0, out_port} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, out_port, e.val);
    end
  endtask

  task automatic test_data_read();
    exp_t e;
    logic [31:0] v;
    bus_write(3'd1, 32'hF0);
    bus_write(3'd0, 32'hFFFF_FFFF);
    in_port = 8'h05;
    repeat (4) @(negedge clk);
    sb.push_back('{"oe_dir", 32'hF0});
    sb.push_back('{"data_mixed", 32'hF5});
    sb.push_back('{"dir_read", 32'hF0});
    e = sb.pop_front(); n_checks++;
    if ({24'h0, oe} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, oe, e.val);
    end
    bus_read(3'd0, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
    bus_read(3'd1, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
  endtask

  task automatic test_edge_irq();
    exp_t e;
    logic [31:0] v;
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
    sb.push_back('{"edge_cleared", 32'h0});
    bus_read(3'd3, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
    @(negedge clk);
    in_port = 8'h01;
    repeat (2) @(negedge clk);
    sb.push_back('{"edge_early", 32'h0});
    bus_read(3'd3, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
    @(negedge clk);
    sb.push_back('{"edge_set", 32'h01});
    sb.push_back('{"irq_set", 32'h1});
    bus_read(3'd3, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
    e = sb.pop_front(); n_checks++;
    if ({31'h0, irq} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, irq, e.val);
    end
    @(negedge clk);
    bus_write(3'd3, 32'h01);
    sb.push_back('{"irq_cleared", 32'h0});
    e = sb.pop_front(); n_checks++;
    if ({31'h0, irq} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, irq, e.val);
    end
    // falling edge ignored; masked rise captured without irq
    in_port = 8'h02;
    repeat (4) @(negedge clk);
    sb.push_back('{"masked_edge", 32'h02});
    sb.push_back('{"masked_irq", 32'h0});
    bus_read(3'd3, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
    e = sb.pop_front(); n_checks++;
    if ({31'h0, irq} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, irq, e.val);
    end
    @(negedge clk);
    bus_write(3'd2, 32'h02);
    sb.push_back('{"unmask_irq", 32'h1});
    e = sb.pop_front(); n_checks++;
    if ({31'h0, irq} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, irq, e.val);
    end
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
  endtask

  task automatic test_set_wins();
    exp_t e;
    logic [31:0] v;
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    bus_write(3'd3, 32'hFF);
    in_port = 8'h01;
    repeat (2) @(negedge clk);
    bus_write(3'd3, 32'h01);
    sb.push_back('{"set_wins", 32'h01});
    bus_read(3'd3, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] v;
    @(negedge clk);
    sb.push_back('{"pre_rst_irq", 32'h1});
    e = sb.pop_front(); n_checks++;
    if ({31'h0, irq} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, irq, e.val);
    end
    bus_write(3'd1, 32'hFF);
    address    = 3'd0;
    writedata  = 32'h12;
    chipselect = 1'b1;
    write_n    = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back('{"mid_rst_out", 32'hA5});
    sb.push_back('{"mid_rst_oe", 32'h00});
    sb.push_back('{"mid_rst_irq", 32'h0});
    e = sb.pop_front(); n_checks++;
    if ({24'h0, out_port} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, out_port, e.val);
    end
    e = sb.pop_front(); n_checks++;
    if ({24'h0, oe} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, oe, e.val);
    end
    e = sb.pop_front(); n_checks++;
    if ({31'h0, irq} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, irq, e.val);
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b1;
    @(negedge clk);
    bus_write(3'd6, 32'hFF);
    sb.push_back('{"addr6_zero", 32'h0});
    bus_read(3'd6, v);
    e = sb.pop_front(); n_checks++;
    if (v !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, v, e.val);
    end
    sb.push_back('{"post_rst_out", 32'hA5});
    e = sb.pop_front(); n_checks++;
    if ({24'h0, out_port} !== e.val) begin
      n_fail++;
      $display("FAIL %s got=%h need=%h", e.name, out_port, e.val);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_data_read();
    test_edge_irq();
    test_set_wins();
    bus_write(3'd2, 32'h01);
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d need=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
